// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and constants for the UART boot loader
package uart_pkg;

   typedef enum logic [3:0] {
      Idle,
      Sync,
      LenLo,
      LenHi,
      Data,
      Write,
      Check,
      Done,
      Error
   } loader_state_e;

   localparam logic [7:0] SYNC_BYTE = 8'hA5;
   localparam int         LEN_WIDTH = 16;

endpackage

// File: rtl/uart_boot_loader.sv
// rtl/uart_boot_loader.sv - turns the uart_rx byte stream into IMEM writes and holds the CPU in reset
module uart_boot_loader
   import uart_pkg::*;
#(
   parameter int                    ADDR_WIDTH   = 32,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR    = '0,
   parameter int                    MAX_WORDS    = 4096,
   parameter int                    TIMEOUT_CLKS = 1_000_000
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  boot_en_i,
   input  logic                  rx_dv_i,
   input  logic [7:0]            rx_data_i,
   output logic                  mem_req_o,
   input  logic                  mem_gnt_i,
   output logic [ADDR_WIDTH-1:0] mem_addr_o,
   output logic [31:0]           mem_wdata_o,
   output logic [3:0]            mem_be_o,
   output logic                  cpu_rst_o,
   output logic                  busy_o,
   output logic                  done_o,
   output logic                  err_o
);

   loader_state_e         state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [31:0]           wdata_q, wdata_d;
   logic [LEN_WIDTH-1:0]  len_q, len_d;
   logic [LEN_WIDTH-1:0]  word_q, word_d;
   logic [1:0]            byte_q, byte_d;
   logic [7:0]            sum_q, sum_d;
   logic [31:0]           to_q;
   logic                  done_q;
   logic                  busy;
   logic                  timeout_hit;
   logic [LEN_WIDTH-1:0]  len_rx;

   assign busy        = (state_q == LenLo) || (state_q == LenHi) || (state_q == Data) ||
                        (state_q == Write) || (state_q == Check);
   assign timeout_hit = busy && !rx_dv_i && (to_q == 32'(TIMEOUT_CLKS - 1));
   assign len_rx      = {rx_data_i, len_q[7:0]};

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= Idle;
         addr_q  <= BASE_ADDR;
         wdata_q <= '0;
         len_q   <= '0;
         word_q  <= '0;
         byte_q  <= '0;
         sum_q   <= '0;
         to_q    <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         len_q   <= len_d;
         word_q  <= word_d;
         byte_q  <= byte_d;
         sum_q   <= sum_d;
         to_q    <= (!busy || rx_dv_i) ? 32'd0 : to_q + 32'd1;
         done_q  <= (state_q == Done);
      end
   end

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      len_d   = len_q;
      word_d  = word_q;
      byte_d  = byte_q;
      sum_d   = sum_q;
      if (timeout_hit) begin
         state_d = Error;
      end else begin
         case (state_q)
            Idle: state_d = boot_en_i ? Sync : Done;
            Sync, Error: begin
               if (rx_dv_i && rx_data_i == SYNC_BYTE) begin
                  state_d = LenLo;
                  sum_d   = '0;
                  addr_d  = BASE_ADDR;
               end
            end
            LenLo: begin
               if (rx_dv_i) begin
                  len_d[7:0] = rx_data_i;
                  state_d    = LenHi;
               end
            end
            LenHi: begin
               if (rx_dv_i) begin
                  len_d[15:8] = rx_data_i;
                  word_d      = '0;
                  byte_d      = '0;
                  if (len_rx == '0 || 32'(len_rx) > 32'(MAX_WORDS)) state_d = Error;
                  else                                               state_d = Data;
               end
            end
            Data: begin
               if (rx_dv_i) begin
                  // little-endian: after four shifts the first byte sits in [7:0]
                  wdata_d = {rx_data_i, wdata_q[31:8]};
                  sum_d   = sum_q + rx_data_i;
                  byte_d  = byte_q + 2'd1;
                  if (byte_q == 2'd3) state_d = Write;
               end
            end
            Write: begin
               // a byte arriving before the write retires is an overrun, even alongside the grant
               if (rx_dv_i) begin
                  state_d = Error;
               end else if (mem_gnt_i) begin
                  word_d  = word_q + 16'd1;
                  addr_d  = addr_q + ADDR_WIDTH'(4);
                  state_d = (word_q + 16'd1 == len_q) ? Check : Data;
               end
            end
            Check: begin
               if (rx_dv_i) state_d = (rx_data_i == sum_q) ? Done : Error;
            end
            Done:    state_d = Done;
            default: state_d = Idle;
         endcase
      end
   end

   assign mem_req_o   = (state_q == Write);
   assign mem_addr_o  = addr_q;
   assign mem_wdata_o = wdata_q;
   assign mem_be_o    = 4'hF;
   assign done_o      = done_q;
   assign cpu_rst_o   = !done_q;
   assign busy_o      = busy;
   assign err_o       = (state_q == Error);

endmodule

// File: tb/tb_uart_boot_loader.sv
// tb/tb_uart_boot_loader.sv - directed self-checking bench for uart_boot_loader
module tb_uart_boot_loader;

   localparam int          MAX_W = 8;
   localparam int          TO    = 40;
   localparam logic [31:0] BASE  = 32'h100;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        boot_en = 1'b0;
   logic        rx_dv = 1'b0;
   logic [7:0]  rx_data = 8'h00;
   logic        mem_req;
   logic        mem_gnt = 1'b0;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_be;
   logic        cpu_rst, busy, done, err;

   int          n_checks = 0;
   int          n_fail = 0;
   int          req_age = 0;
   bit          req_seen = 0;
   bit          gnt_en = 1;
   logic [31:0] wr_addr[$];
   logic [31:0] wr_data[$];

   uart_boot_loader #(
      .ADDR_WIDTH  (32),
      .BASE_ADDR   (BASE),
      .MAX_WORDS   (MAX_W),
      .TIMEOUT_CLKS(TO)
   ) dut (
      .clk_i      (clk),
      .rst_i      (rst),
      .boot_en_i  (boot_en),
      .rx_dv_i    (rx_dv),
      .rx_data_i  (rx_data),
      .mem_req_o  (mem_req),
      .mem_gnt_i  (mem_gnt),
      .mem_addr_o (mem_addr),
      .mem_wdata_o(mem_wdata),
      .mem_be_o   (mem_be),
      .cpu_rst_o  (cpu_rst),
      .busy_o     (busy),
      .done_o     (done),
      .err_o      (err)
   );

   always #5 clk = ~clk;

   // IMEM model: grants after the request has been visible for two negedges
   always @(negedge clk) begin
      if (mem_req) begin
         req_seen = 1;
         req_age++;
      end else begin
         req_age = 0;
      end
      mem_gnt = gnt_en && mem_req && (req_age >= 2);
      if (mem_gnt) begin
         wr_addr.push_back(mem_addr);
         wr_data.push_back(mem_wdata);
      end
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      rx_data = b;
      rx_dv   = 1'b1;
      @(posedge clk); #1;
      rx_dv = 1'b0;
      repeat (6) @(posedge clk);
      #1;
   endtask

   task automatic send_frame(input logic [7:0] last);
      logic [7:0] f[11];
      f = '{8'hA5, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
      foreach (f[i]) send_byte(f[i]);
      send_byte(last);
   endtask

   task automatic check_reset_values(input string pfx);
      check_eq({pfx, "_req"},   mem_req,   0);
      check_eq({pfx, "_addr"},  mem_addr,  BASE);
      check_eq({pfx, "_wdata"}, mem_wdata, 0);
      check_eq({pfx, "_cpurst"}, cpu_rst,  1);
      check_eq({pfx, "_busy"},  busy,      0);
      check_eq({pfx, "_done"},  done,      0);
      check_eq({pfx, "_err"},   err,       0);
   endtask

   // leaves the DUT in Sync (or Done when boot_en=0) at posedge+1
   task automatic do_reset(input bit en, input bit chk);
      rst     = 1'b1;
      boot_en = en;
      rx_dv   = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      if (chk) check_reset_values("rst");
      rst = 1'b0;
      @(posedge clk); #1;
      wr_addr.delete();
      wr_data.delete();
      req_seen = 0;
   endtask

   initial begin
      // boot disabled
      do_reset(0, 1);
      @(posedge clk); #1;
      check_eq("skip_done", done, 1);
      check_eq("skip_cpurst", cpu_rst, 0);
      check_eq("skip_be", mem_be, 4'hF);
      repeat (5) @(posedge clk);
      #1;
      check_eq("skip_noreq", req_seen, 0);

      // valid frame after junk
      do_reset(1, 0);
      send_byte(8'h00);
      send_byte(8'hFF);
      check_eq("junk_busy", busy, 0);
      send_frame(8'h64);
      check_eq("ok_nwr", wr_addr.size(), 2);
      if (wr_addr.size() == 2) begin
         check_eq("ok_a0", wr_addr[0], BASE);
         check_eq("ok_d0", wr_data[0], 32'h44332211);
         check_eq("ok_a1", wr_addr[1], BASE + 4);
         check_eq("ok_d1", wr_data[1], 32'h88776655);
      end
      check_eq("ok_addr_end", mem_addr, BASE + 8);
      check_eq("ok_done", done, 1);
      check_eq("ok_cpurst", cpu_rst, 0);
      check_eq("ok_err", err, 0);
      send_byte(8'hA5);
      check_eq("done_sticky", done, 1);

      // bad checksum, then resend
      do_reset(1, 0);
      send_frame(8'h65);
      check_eq("bad_err", err, 1);
      check_eq("bad_cpurst", cpu_rst, 1);
      check_eq("bad_done", done, 0);
      wr_addr.delete();
      wr_data.delete();
      send_byte(8'hA5);
      check_eq("resync_err", err, 0);
      check_eq("resync_addr", mem_addr, BASE);
      send_byte(8'h02);
      send_byte(8'h00);
      for (int i = 0; i < 8; i++) send_byte(8'h11 * (i + 1));
      send_byte(8'h64);
      check_eq("resend_done", done, 1);
      check_eq("resend_nwr", wr_addr.size(), 2);
      if (wr_addr.size() == 2) check_eq("resend_a0", wr_addr[0], BASE);

      // illegal and boundary lengths
      do_reset(1, 0);
      send_byte(8'hA5); send_byte(8'h00); send_byte(8'h00);
      check_eq("len0_err", err, 1);
      send_byte(8'hA5); send_byte(8'h09); send_byte(8'h00);
      check_eq("lenmax1_err", err, 1);
      check_eq("lenmax1_busy", busy, 0);
      send_byte(8'hA5); send_byte(8'h08); send_byte(8'h00);
      check_eq("lenmax_err", err, 0);
      check_eq("lenmax_busy", busy, 1);
      check_eq("len_noreq", req_seen, 0);

      // overrun: grant withheld, next byte arrives
      do_reset(1, 0);
      gnt_en = 0;
      send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00);
      send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
      check_eq("ovr_req_hold", mem_req, 1);
      check_eq("ovr_wdata", mem_wdata, 32'h44332211);
      send_byte(8'h55);
      check_eq("ovr_err", err, 1);
      check_eq("ovr_req_drop", mem_req, 0);
      check_eq("ovr_addr", mem_addr, BASE);
      check_eq("ovr_nwr", wr_addr.size(), 0);
      gnt_en = 1;

      // timeout after the third data byte
      do_reset(1, 0);
      send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00);
      send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
      check_eq("to_pre_err", err, 0);
      repeat (TO) @(posedge clk);
      #1;
      check_eq("to_err", err, 1);
      check_eq("to_busy", busy, 0);

      // reset mid-WRITE
      do_reset(1, 0);
      gnt_en = 0;
      send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00);
      send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
      check_eq("mid_req", mem_req, 1);
      rst = 1'b1;
      @(posedge clk); #1;
      check_reset_values("mid");
      rst    = 1'b0;
      gnt_en = 1;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
